// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser.
//   RES_W      : width of the gate-stage result vector
//   G_*        : bit positions of each gate inside the result vector
//   state_t    : sequencer state encoding
package gate_exerciser_pkg;

  localparam int unsigned RES_W = 7;

  localparam int unsigned G_AND  = 0;
  localparam int unsigned G_OR   = 1;
  localparam int unsigned G_NOTA = 2;
  localparam int unsigned G_NAND = 3;
  localparam int unsigned G_NOR  = 4;
  localparam int unsigned G_XOR  = 5;
  localparam int unsigned G_XNOR = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gate_expected.sv
// Combinational golden gate model.
//   a, b : operands
//   y    : expected results, one bit per gate at the G_* positions
module gate_expected
  import gate_exerciser_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] y
);

  always_comb begin
    y         = '0;
    y[G_AND]  = a & b;
    y[G_OR]   = a | b;
    y[G_NOTA] = ~a;
    y[G_NAND] = ~(a & b);
    y[G_NOR]  = ~(a | b);
    y[G_XOR]  = a ^ b;
    y[G_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_exerciser.sv
// Gate-stage exerciser: sweeps the four {A,B} vectors PASSES times, holds each
// vector for SETTLE_CYCLES before sampling Q, and records mismatches.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request (only honoured when idle)
//   A, B       : stimulus to the gate stage
//   Q          : gate-stage results (AND, OR, NOT A, NAND, NOR, XOR, XNOR)
//   busy, done : run in progress / one-cycle end-of-run pulse
//   pass       : last completed run had no mismatches
//   err_count  : mismatching checks (saturating)
//   fail_vec   : {A,B} of the first failing check
//   fail_mask  : Q ^ expected at the first failing check
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic [RES_W-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [1:0]       fail_vec,
  output logic [RES_W-1:0] fail_mask
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  state_t           state, state_next;
  logic [1:0]       idx;
  logic [1:0]       idx_succ;
  logic [7:0]       pass_cnt;
  logic [3:0]       settle_cnt;
  logic [RES_W-1:0] expected;
  logic [RES_W-1:0] diff;
  logic             mismatch;
  logic             last_check;

  // A/B come straight from the vector index, so they only move when idx does,
  // which is exactly on entry to APPLY.
  assign A = idx[1];
  assign B = idx[0];

  gate_expected u_expected (
    .a (A),
    .b (B),
    .y (expected)
  );

  assign diff       = Q ^ expected;
  assign mismatch   = |diff;
  assign idx_succ   = idx + 2'd1;
  assign last_check = (idx == 2'd3) && (pass_cnt == PASS_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_APPLY;
      end
      ST_APPLY:  state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
      ST_CHECK:  state_next = last_check ? ST_DONE : ST_APPLY;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_mask  <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            pass_cnt  <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
          end
        end
        ST_APPLY:  settle_cnt <= '0;
        ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            // err_count never wraps, so zero means no earlier mismatch this run
            if (err_count == '0) begin
              fail_vec  <= {A, B};
              fail_mask <= diff;
            end
          end
          if (last_check) begin
            // Uses the post-check count so pass is valid alongside done.
            pass <= (err_count == '0) && !mismatch;
          end else begin
            idx <= idx_succ;
            if (idx == 2'd3) pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (defaults, and PASSES=3) drive a
// fault-injectable gate stage; expected run results go into per-instance
// queues and a monitor compares them whenever done is presented.
module tb_gate_exerciser;

  localparam int unsigned N = 2;

  typedef struct packed {
    logic [31:0] done_edge;
    logic [7:0]  err;
    logic [1:0]  fvec;
    logic [6:0]  fmask;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [N];
  logic       A_v     [N];
  logic       B_v     [N];
  logic       busy_v  [N];
  logic       done_v  [N];
  logic       pass_v  [N];
  logic [6:0] q_v     [N];
  logic [7:0] err_v   [N];
  logic [1:0] fvec_v  [N];
  logic [6:0] fmask_v [N];

  logic [6:0] sa0_r  [N];
  logic [6:0] sa1_r  [N];
  logic [6:0] flip_r [N];
  logic [1:0] fsel_r [N];

  exp_t        sb       [N][16];
  exp_t        last_exp [N];
  int unsigned wr [N] = '{default: 0};
  int unsigned rd [N] = '{default: 0};

  int checks   = 0;
  int failures = 0;

  // Gate truth table by {a,b}; bits 6..0 = XNOR XOR NOR NAND NOTA OR AND.
  function automatic logic [6:0] truth(input logic [1:0] ab);
    case (ab)
      2'b00:   return 7'b1011100;
      2'b01:   return 7'b0101110;
      2'b10:   return 7'b0101010;
      default: return 7'b1000011;
    endcase
  endfunction

  // Faulty gate stage: stuck-at-0/1 masks plus a flip applied on one vector.
  function automatic logic [6:0] stage_out(input logic [1:0] ab, input logic [6:0] s0,
                                           input logic [6:0] s1, input logic [6:0] fl,
                                           input logic [1:0] fs);
    logic [6:0] q;
    q = (truth(ab) & ~s0) | s1;
    if (ab == fs) q = q ^ fl;
    return q;
  endfunction

  function automatic int unsigned passes_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned latency(input int unsigned passes);
    return passes * 4 * (2 + 2) + 1;
  endfunction

  function automatic exp_t model(input int unsigned passes, input logic [6:0] s0,
                                 input logic [6:0] s1, input logic [6:0] fl,
                                 input logic [1:0] fs);
    exp_t        e;
    int unsigned errs;
    logic [6:0]  d;
    e    = '0;
    errs = 0;
    for (int unsigned p = 0; p < passes; p++) begin
      for (int unsigned v = 0; v < 4; v++) begin
        d = stage_out(2'(v), s0, s1, fl, fs) ^ truth(2'(v));
        if (d != '0) begin
          if (errs == 0) begin
            e.fvec  = 2'(v);
            e.fmask = d;
          end
          errs++;
        end
      end
    end
    e.err  = (errs > 255) ? 8'hFF : 8'(errs);
    e.pass = (errs == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    gate_exerciser #(
      .SETTLE_CYCLES (2),
      .PASSES        ((g == 0) ? 1 : 3)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[g]),
      .A         (A_v[g]),
      .B         (B_v[g]),
      .Q         (q_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .err_count (err_v[g]),
      .fail_vec  (fvec_v[g]),
      .fail_mask (fmask_v[g])
    );

    assign q_v[g] = stage_out({A_v[g], B_v[g]}, sa0_r[g], sa1_r[g], flip_r[g], fsel_r[g]);

    always @(negedge clk) begin
      if (!rst && done_v[g] === 1'b1) begin
        if (rd[g] == wr[g]) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done inst=%0d actual=1 required=0 (t=%0t)", g, $time);
        end else begin
          exp_t e;
          e = sb[g][rd[g] % 16];
          rd[g]++;
          check($sformatf("latency_edge[%0d]", g), cyc + 1, e.done_edge);
          check($sformatf("err_count[%0d]", g), 32'(err_v[g]), 32'(e.err));
          check($sformatf("fail_vec[%0d]", g), 32'(fvec_v[g]), 32'(e.fvec));
          check($sformatf("fail_mask[%0d]", g), 32'(fmask_v[g]), 32'(e.fmask));
          check($sformatf("pass[%0d]", g), 32'(pass_v[g]), 32'(e.pass));
          check($sformatf("busy_in_done[%0d]", g), 32'(busy_v[g]), 32'd1);
        end
      end
    end
  end

  task automatic set_faults(input int g, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] fl, input logic [1:0] fs);
    sa0_r[g]  = s0;
    sa1_r[g]  = s1;
    flip_r[g] = fl;
    fsel_r[g] = fs;
  endtask

  task automatic push(input int g, input exp_t e);
    sb[g][wr[g] % 16] = e;
    wr[g]++;
    last_exp[g] = e;
  endtask

  task automatic wait_idle(input int g);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while ((rd[g] != wr[g] || busy_v[g] !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL run_timeout inst=%0d actual=busy required=idle (t=%0t)", g, $time);
      rd[g] = wr[g];
    end
  endtask

  task automatic check_held(input int g);
    repeat (2) @(negedge clk);
    check($sformatf("idle_busy[%0d]", g), 32'(busy_v[g]), 32'd0);
    check($sformatf("idle_err[%0d]", g), 32'(err_v[g]), 32'(last_exp[g].err));
    check($sformatf("idle_fvec[%0d]", g), 32'(fvec_v[g]), 32'(last_exp[g].fvec));
    check($sformatf("idle_fmask[%0d]", g), 32'(fmask_v[g]), 32'(last_exp[g].fmask));
    check($sformatf("idle_pass[%0d]", g), 32'(pass_v[g]), 32'(last_exp[g].pass));
    check($sformatf("idle_ab[%0d]", g), 32'({A_v[g], B_v[g]}), 32'd3);
  endtask

  task automatic run(input int g, input logic [6:0] s0, input logic [6:0] s1,
                     input logic [6:0] fl, input logic [1:0] fs, input int unsigned poke);
    exp_t e;
    @(negedge clk);
    set_faults(g, s0, s1, fl, fs);
    start_v[g] = 1'b1;
    e = model(passes_of(g), s0, s1, fl, fs);
    e.done_edge = cyc + 1 + latency(passes_of(g));
    push(g, e);
    @(negedge clk);
    start_v[g] = 1'b0;
    if (poke != 0) begin
      // start while busy must be ignored
      repeat (poke) @(negedge clk);
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
    end
    wait_idle(g);
    check_held(g);
  endtask

  task automatic run_held_start();
    exp_t        e;
    int unsigned s;
    @(negedge clk);
    set_faults(0, 7'h00, 7'h00, 7'h00, 2'b00);
    start_v[0] = 1'b1;
    s = cyc + 1;
    e = model(1, 7'h00, 7'h00, 7'h00, 2'b00);
    e.done_edge = s + latency(1);
    push(0, e);
    e.done_edge = s + latency(1) + 1 + latency(1);
    push(0, e);
    repeat (19) @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);
    check_held(0);
  endtask

  task automatic run_reset_mid();
    int unsigned n;
    int unsigned errs;
    @(negedge clk);
    set_faults(0, 7'h00, 7'h7F, 7'h00, 2'b00);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!(A_v[0] === 1'b1 && B_v[0] === 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec10", 32'(n < 40), 32'd1);
    errs = 0;
    for (int unsigned v = 0; v < 2; v++)
      if (stage_out(2'(v), 7'h00, 7'h7F, 7'h00, 2'b00) != truth(2'(v))) errs++;
    check("err_before_rst", 32'(err_v[0]), errs);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_ab", 32'({A_v[0], B_v[0]}), 32'd0);
    check("rst_err", 32'(err_v[0]), 32'd0);
    check("rst_fvec", 32'(fvec_v[0]), 32'd0);
    check("rst_fmask", 32'(fmask_v[0]), 32'd0);
    check("rst_pass", 32'(pass_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    // the monitor flags any done pulse appearing while nothing is queued
    repeat (30) @(negedge clk);
    check("rst_stays_idle", 32'(busy_v[0]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      set_faults(i, 7'h00, 7'h00, 7'h00, 2'b00);
    end
    rst = 1'b1;
    // start asserted with reset: reset must win
    start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset_done[%0d]", i), 32'(done_v[i]), 32'd0);
      check($sformatf("reset_pass[%0d]", i), 32'(pass_v[i]), 32'd0);
      check($sformatf("reset_ab[%0d]", i), 32'({A_v[i], B_v[i]}), 32'd0);
      check($sformatf("reset_err[%0d]", i), 32'(err_v[i]), 32'd0);
      check($sformatf("reset_fvec[%0d]", i), 32'(fvec_v[i]), 32'd0);
      check($sformatf("reset_fmask[%0d]", i), 32'(fmask_v[i]), 32'd0);
    end
    start_v[0] = 1'b0;
    rst = 1'b0;

    run(0, 7'h00, 7'h00, 7'h00, 2'b00, 0);   // clean stage, defaults
    run(0, 7'h20, 7'h00, 7'h00, 2'b00, 3);   // XOR stuck at 0
    run(1, 7'h00, 7'h01, 7'h00, 2'b00, 5);   // AND stuck at 1, three passes
    run(0, 7'h00, 7'h7F, 7'h00, 2'b00, 0);   // all outputs high
    run(1, 7'h00, 7'h00, 7'h00, 2'b00, 0);
    run(0, 7'h00, 7'h00, 7'h11, 2'b10, 0);   // single-vector corruption
    run_held_start();
    run_reset_mid();
    run(0, 7'h00, 7'h00, 7'h00, 2'b00, 0);   // recovers after abort

    for (int k = 0; k < 14; k++) begin
      int          g;
      logic [6:0]  s0, s1, fl;
      logic [1:0]  fs;
      g  = int'($urandom_range(0, 1));
      s0 = 7'($urandom & $urandom & $urandom);
      s1 = 7'($urandom & $urandom & $urandom);
      fl = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      fs = 2'($urandom);
      run(g, s0, s1, fl, fs, $urandom_range(0, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished (t=%0t)", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
